cpu6_dmem_resp: RTL and testbench

//  Data-memory responder for the cpu6 MEM stage: services the load/store requests the

---
 rtl/cpu6_dmem_resp_pkg.sv | 16 +
 rtl/cpu6_storebuf.sv | 84 ++++++++
 rtl/cpu6_dmem_resp.sv | 151 +++++++++++++++
 tb/tb_cpu6_dmem_resp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_dmem_resp_pkg.sv
// rtl/cpu6_dmem_resp_pkg.sv - shared state encoding and helpers for the cpu6 data-memory responder
package cpu6_dmem_resp_pkg;

   localparam int ST_SIZE = 2;

   typedef enum logic [ST_SIZE-1:0] {
      ST_IDLE  = 2'd0,
      ST_RWAIT = 2'd1,
      ST_RDONE = 2'd2
   } dmemState_t;

   function automatic logic isMisaligned(input logic [1:0] byteOfs);
      return byteOfs != 2'b00;
   endfunction

endpackage

// File: rtl/cpu6_storebuf.sv
// rtl/cpu6_storebuf.sv - posted-write circular store buffer with youngest-hit load forwarding
module cpu6_storebuf #(
   parameter int XLEN  = 32,
   parameter int AW    = 10,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic [AW-1:0]   pushAddr,
   input  logic [XLEN-1:0] pushData,
   input  logic            pop,
   output logic [AW-1:0]   headAddr,
   output logic [XLEN-1:0] headData,
   output logic            full,
   output logic            empty,
   input  logic [AW-1:0]   lookupAddr,
   output logic            hit,
   output logic [XLEN-1:0] hitData
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0]    addrQ [DEPTH];
   logic [XLEN-1:0]  dataQ [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    pos;
   logic [PW:0]      count;
   logic [PW:0]      countNext;

   always_comb begin
      countNext = count;
      if (push && !pop) begin
         countNext = count + (PW+1)'(1);
      end else if (pop && !push) begin
         countNext = count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         valid <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push) begin
            addrQ[wrPtr] <= pushAddr;
            dataQ[wrPtr] <= pushData;
            valid[wrPtr] <= 1'b1;
            wrPtr        <= wrPtr + PW'(1);
         end
         if (pop) begin
            valid[rdPtr] <= 1'b0;
            rdPtr        <= rdPtr + PW'(1);
         end
         count <= countNext;
         full  <= (countNext == (PW+1)'(DEPTH));
         empty <= (countNext == '0);
      end
   end

   // Scan oldest to youngest so the last match (youngest store) wins.
   always_comb begin
      hit     = 1'b0;
      hitData = '0;
      pos     = rdPtr;
      for (int k = 0; k < DEPTH; k++) begin
         pos = rdPtr + PW'(k);
         if (valid[pos] && (addrQ[pos] == lookupAddr)) begin
            hit     = 1'b1;
            hitData = dataQ[pos];
         end
      end
   end

   assign headAddr = addrQ[rdPtr];
   assign headData = dataQ[rdPtr];

endmodule

// File: rtl/cpu6_dmem_resp.sv
// rtl/cpu6_dmem_resp.sv - cpu6 MEM-stage data memory: RAM array, store buffer, read-latency FSM
module cpu6_dmem_resp
   import cpu6_dmem_resp_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int AW          = 10,
   parameter int SB_DEPTH    = 2,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            memreqM,
   input  logic            memwriteM,
   input  logic [XLEN-1:0] dataaddrM,
   input  logic [XLEN-1:0] writedataM,
   output logic [XLEN-1:0] readdataM,
   output logic            stallM,
   output logic            misalignM
);

   logic [XLEN-1:0] mem [2**AW];

   dmemState_t      state;
   logic [3:0]      waitCnt;
   logic [AW-1:0]   idx;
   logic [AW-1:0]   missIdx;
   logic [XLEN-1:0] lastData;
   logic [XLEN-1:0] loadData;
   logic            reqMis;
   logic            isLoad;
   logic            isStore;
   logic            push;
   logic            pop;
   logic            loadDone;
   logic            loadStall;
   logic            startMiss;
   logic            sbFull;
   logic            sbEmpty;
   logic            sbHit;
   logic [AW-1:0]   sbHeadAddr;
   logic [XLEN-1:0] sbHeadData;
   logic [XLEN-1:0] sbHitData;
   logic            unusedAddrBits;

   assign idx            = dataaddrM[AW+1:2];
   assign unusedAddrBits = ^dataaddrM[XLEN-1:AW+2];
   assign reqMis         = memreqM && isMisaligned(dataaddrM[1:0]);
   assign isLoad         = memreqM && !memwriteM && !reqMis;
   assign isStore        = memreqM && memwriteM && !reqMis;
   assign push           = reset && isStore && !sbFull;
   assign pop            = reset && (state == ST_IDLE) && !sbEmpty;

   cpu6_storebuf #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (SB_DEPTH)
   ) u_storebuf (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pushAddr   (idx),
      .pushData   (writedataM),
      .pop        (pop),
      .headAddr   (sbHeadAddr),
      .headData   (sbHeadData),
      .full       (sbFull),
      .empty      (sbEmpty),
      .lookupAddr (idx),
      .hit        (sbHit),
      .hitData    (sbHitData)
   );

   always_comb begin
      loadDone  = 1'b0;
      loadData  = '0;
      loadStall = 1'b0;
      startMiss = 1'b0;
      case (state)
         ST_IDLE: begin
            if (reqMis && !memwriteM) begin
               loadDone = 1'b1;
            end else if (isLoad) begin
               if (sbHit) begin
                  loadDone = 1'b1;
                  loadData = sbHitData;
               end else if (WAIT_CYCLES == 0) begin
                  loadDone = 1'b1;
                  loadData = mem[idx];
               end else begin
                  startMiss = 1'b1;
                  loadStall = 1'b1;
               end
            end
         end
         ST_RWAIT: loadStall = isLoad;
         // Array read uses the index latched at the miss, not the live address.
         ST_RDONE: begin
            loadDone = 1'b1;
            loadData = mem[missIdx];
         end
         default: ;
      endcase
   end

   assign stallM    = reset && (loadStall || (isStore && sbFull));
   assign misalignM = reset && reqMis;
   assign readdataM = !reset ? '0 : (loadDone ? loadData : lastData);

   always_ff @(posedge clk) begin
      if (pop) begin
         mem[sbHeadAddr] <= sbHeadData;
      end
   end

   // The request cycle itself is the first stall cycle, so RWAIT covers WAIT_CYCLES-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         waitCnt  <= '0;
         missIdx  <= '0;
         lastData <= '0;
      end else begin
         if (loadDone) begin
            lastData <= loadData;
         end
         case (state)
            ST_IDLE: begin
               if (startMiss) begin
                  missIdx <= idx;
                  if (WAIT_CYCLES <= 1) begin
                     state <= ST_RDONE;
                  end else begin
                     state   <= ST_RWAIT;
                     waitCnt <= 4'(WAIT_CYCLES - 2);
                  end
               end
            end
            ST_RWAIT: begin
               if (waitCnt == 4'd0) begin
                  state <= ST_RDONE;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            ST_RDONE: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
// tb/tb_cpu6_dmem_resp.sv - self-checking bench for cpu6_dmem_resp
module tb_cpu6_dmem_resp;

   localparam logic [31:0] A1 = 32'hA1A1_0001;
   localparam logic [31:0] A2 = 32'hA2A2_0002;
   localparam logic [31:0] A3 = 32'hA3A3_0003;
   localparam int          WAITC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        memreqM, memwriteM;
   logic [31:0] dataaddrM, writedataM, readdataM;
   logic        stallM, misalignM;
   logic        zreq, zwr;
   logic [31:0] zaddr, zwd, zrd;
   logic        zstall, zmis;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rs;
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        expStall;
      logic [31:0] expRd;
      logic        expMis;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] model [8];

   always #5 clk = ~clk;

   cpu6_dmem_resp #(.XLEN(32), .AW(10), .SB_DEPTH(2), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .reset(reset), .memreqM(memreqM), .memwriteM(memwriteM),
      .dataaddrM(dataaddrM), .writedataM(writedataM), .readdataM(readdataM),
      .stallM(stallM), .misalignM(misalignM)
   );

   cpu6_dmem_resp #(.XLEN(32), .AW(10), .SB_DEPTH(2), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .memreqM(zreq), .memwriteM(zwr),
      .dataaddrM(zaddr), .writedataM(zwd), .readdataM(zrd),
      .stallM(zstall), .misalignM(zmis)
   );

   function automatic vec_t V(input logic rs, input logic req, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic es, input logic [31:0] er, input logic em);
      vec_t v;
      v.rs = rs; v.req = req; v.wr = wr; v.addr = addr; v.wd = wd;
      v.expStall = es; v.expRd = er; v.expMis = em;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      reset      = v.rs;
      memreqM    = v.req;
      memwriteM  = v.wr;
      dataaddrM  = v.addr;
      writedataM = v.wd;
      @(negedge clk);
      chk({tag, " stallM"}, 32'(stallM), 32'(v.expStall));
      chk({tag, " readdataM"}, readdataM, v.expRd);
      chk({tag, " misalignM"}, 32'(misalignM), 32'(v.expMis));
      @(posedge clk);
      #1;
   endtask

   // Reference: a load returns the latest store to the same word index, whatever is buffered.
   task automatic txn(input logic wr, input int k, input logic [1:0] lo, input logic [31:0] wd);
      logic [31:0] a;
      int          n;
      a = ($urandom() & 32'hFFFF_F000) | ((32'h180 + 32'(k)) << 2) | {30'd0, lo};
      memreqM = 1'b1; memwriteM = wr; dataaddrM = a; writedataM = wd;
      n = 0;
      @(negedge clk);
      while (stallM && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (stallM) begin
         checks++;
         errors++;
         $display("FAIL rnd timeout actual=stalled required=complete addr=%h", a);
      end else begin
         chk("rnd misalignM", 32'(misalignM), 32'(lo != 2'b00));
         if (lo != 2'b00) begin
            chk("rnd misaligned stall cycles", 32'(n), 32'd0);
            if (!wr) chk("rnd misaligned readdataM", readdataM, 32'd0);
         end else if (!wr) begin
            chk("rnd readdataM", readdataM, model[k]);
            checks++;
            if (n != 0 && n != WAITC) begin
               errors++;
               $display("FAIL rnd load stall cycles actual=%0d required=0 or %0d", n, WAITC);
            end
         end else begin
            model[k] = wd;
         end
      end
      @(posedge clk);
      #1;
      memreqM = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; memreqM = 1'b0; memwriteM = 1'b0; dataaddrM = '0; writedataM = '0;
      zreq = 1'b0; zwr = 1'b0; zaddr = '0; zwd = '0;
      repeat (2) @(posedge clk);
      #1;

      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h100, 0,            0, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 1, 1, 32'h200, 32'h12345678, 0, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 1, 0, 32'h200, 0,            1, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 1, 0, 32'h200, 0,            1, 32'hDEADBEEF, 0));
      tbl.push_back(V(1, 1, 0, 32'h200, 0,            0, 32'h12345678, 0));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 1, 32'h040, 32'd1,        0, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 1, 32'h040, 32'd2,        0, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 0, 32'h040, 0,            0, 32'd2,        0));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'd2,        0));
      tbl.push_back(V(1, 1, 0, 32'h040, 0,            1, 32'd2,        0));
      tbl.push_back(V(1, 1, 0, 32'h040, 0,            1, 32'd2,        0));
      tbl.push_back(V(1, 1, 0, 32'h040, 0,            0, 32'd2,        0));
      tbl.push_back(V(1, 1, 0, 32'h103, 0,            0, 32'h0,        1));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'h0,        0));
      tbl.push_back(V(1, 1, 0, 32'h200, 0,            1, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h300, A1,           0, 32'h0,        0));
      tbl.push_back(V(1, 1, 1, 32'h304, A2,           0, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 1, 32'h308, A3,           1, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 1, 32'h308, A3,           0, 32'h12345678, 0));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 0, 32'h300, 0,            1, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 0, 32'h300, 0,            1, 32'h12345678, 0));
      tbl.push_back(V(1, 1, 0, 32'h300, 0,            0, A1,           0));
      tbl.push_back(V(1, 1, 0, 32'h304, 0,            1, A1,           0));
      tbl.push_back(V(1, 1, 0, 32'h304, 0,            1, A1,           0));
      tbl.push_back(V(1, 1, 0, 32'h304, 0,            0, A2,           0));
      tbl.push_back(V(1, 1, 0, 32'h308, 0,            1, A2,           0));
      tbl.push_back(V(1, 1, 0, 32'h308, 0,            1, A2,           0));
      tbl.push_back(V(1, 1, 0, 32'h308, 0,            0, A3,           0));
      tbl.push_back(V(1, 1, 1, 32'h301, 32'hFF,       0, A3,           1));
      tbl.push_back(V(1, 0, 0, 32'h000, 0,            0, A3,           0));
      tbl.push_back(V(1, 1, 0, 32'h80000300, 0,       1, A3,           0));
      tbl.push_back(V(1, 1, 0, 32'h80000300, 0,       1, A3,           0));
      tbl.push_back(V(1, 1, 0, 32'h80000300, 0,       0, A1,           0));

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // Reset during RWAIT with one store still pending in the buffer.
      step(V(1, 1, 1, 32'h310, 32'hC0C0, 0, A1,           0), "rst0");
      step(V(1, 0, 0, 32'h000, 0,        0, A1,           0), "rst1");
      step(V(1, 1, 0, 32'h200, 0,        1, A1,           0), "rst2");
      step(V(1, 1, 1, 32'h30C, 32'hB1,   0, A1,           0), "rst3");
      step(V(1, 1, 1, 32'h310, 32'hB2,   0, 32'h12345678, 0), "rst4");
      step(V(1, 1, 0, 32'h200, 0,        1, 32'h12345678, 0), "rst5");
      step(V(0, 1, 0, 32'h200, 0,        0, 32'h0,        0), "rst6");
      step(V(0, 0, 0, 32'h000, 0,        0, 32'h0,        0), "rst7");
      step(V(1, 0, 0, 32'h000, 0,        0, 32'h0,        0), "rst8");
      step(V(1, 1, 0, 32'h310, 0,        1, 32'h0,        0), "rst9");
      step(V(1, 1, 0, 32'h310, 0,        1, 32'h0,        0), "rst10");
      step(V(1, 1, 0, 32'h310, 0,        0, 32'hC0C0,     0), "rst11");
      memreqM = 1'b0;

      // Zero-latency instance: a miss completes in its request cycle.
      zreq = 1'b1; zwr = 1'b1; zaddr = 32'h20; zwd = 32'h99;
      @(negedge clk);
      chk("w0 store stallM", 32'(zstall), 32'd0);
      @(posedge clk); #1;
      zreq = 1'b0;
      @(posedge clk); #1;
      zreq = 1'b1; zwr = 1'b0;
      @(negedge clk);
      chk("w0 miss stallM", 32'(zstall), 32'd0);
      chk("w0 miss readdataM", zrd, 32'h99);
      chk("w0 miss misalignM", 32'(zmis), 32'd0);
      @(posedge clk); #1;
      zreq = 1'b0;

      for (int k = 0; k < 8; k++) txn(1'b1, k, 2'b00, $urandom());
      for (int t = 0; t < 300; t++) begin
         logic        w;
         int          k;
         logic [1:0]  lo;
         w  = 1'($urandom_range(0, 1));
         k  = int'($urandom_range(0, 7));
         lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         txn(w, k, lo, $urandom());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
